// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and constants for the memory line arbiter.
//   state_t     : arbiter FSM states
//   grant_t     : which cache miss path owns the RAM port
//   LINE_W      : cache line width in bits
//   OFFSET_BITS : byte-offset bits inside one line
//   line_align(): clears the byte offset of an address (up to 64 bits wide)
package mem_pkg;

   localparam int LINE_W      = 128;
   localparam int OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DC = 1'b1
   } grant_t;

   function automatic logic [63:0] line_align(input logic [63:0] addr);
      return {addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Bundle of the cache-side and RAM-side signals of the line arbiter.
//   master : environment side (caches drive requests, RAM drives ram_ack/ram_rdata)
//   slave  : arbiter side
// Signals:
//   ic_req/ic_addr -> ic_rdata/ic_done           instruction-cache fills
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_rdata/dc_done   data-cache fills and write-backs
//   ram_req/ram_we/ram_addr/ram_wdata, ram_rdata/ram_ack RAM handshake
//   busy, err                                    status
interface mem_line_arbiter_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = mem_pkg::LINE_W
);

   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic [LINE_W-1:0] ic_rdata;
   logic              ic_done;

   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [LINE_W-1:0] dc_wdata;
   logic [LINE_W-1:0] dc_rdata;
   logic              dc_done;

   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [LINE_W-1:0] ram_wdata;
   logic [LINE_W-1:0] ram_rdata;
   logic              ram_ack;

   logic              busy;
   logic              err;

   modport master (
      output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, ram_rdata, ram_ack,
      input  ic_rdata, ic_done, dc_rdata, dc_done,
             ram_req, ram_we, ram_addr, ram_wdata, busy, err
   );

   modport slave (
      input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, ram_rdata, ram_ack,
      output ic_rdata, ic_done, dc_rdata, dc_done,
             ram_req, ram_we, ram_addr, ram_wdata, busy, err
   );

endinterface

// File: rtl/mem_line_arbiter_timeout_ctr.sv
// No-ack timeout counter for the RAM handshake.
//   clk, rstn : clock, synchronous active-high reset
//   clear     : forces the count to zero
//   enable    : counts one per cycle, saturating at TIMEOUT
//   expired   : high while enabled in the TIMEOUT-th counted cycle
module mem_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rstn || clear)
         cnt <= '0;
      else if (enable && cnt != CNT_W'(TIMEOUT))
         cnt <= cnt + CNT_W'(1);
   end

   assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-wide RAM port between the ins-cache and data-cache miss paths.
// One transaction at a time, fair arbitration on ties, no-ack timeout with sticky err.
//   clk  : clock
//   rstn : synchronous reset, active high
//   bus  : mem_line_arbiter_if.slave (cache requests, RAM handshake, busy/err)
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the granted request
// REQ   | ram_req held with latched we/addr/wdata until ack or timeout
// DONE  | one-cycle done pulse to the granted port; requester may drop req
module mem_line_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = mem_pkg::LINE_W,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rstn,
   mem_line_arbiter_if.slave bus
);

   state_t state;
   grant_t grant;
   grant_t last_grant;
   grant_t pick;
   logic   expired;

   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
      return ADDR_W'(line_align(64'(a)));
   endfunction

   // Single requester wins outright; on a tie the port not served last time wins.
   always_comb begin
      pick = GNT_IC;
      if (bus.dc_req && (!bus.ic_req || last_grant == GNT_IC))
         pick = GNT_DC;
   end

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (state != REQ),
      .enable  (state == REQ),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rstn) begin
         state         <= IDLE;
         grant         <= GNT_IC;
         last_grant    <= GNT_IC;
         bus.ram_req   <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.ic_rdata  <= '0;
         bus.dc_rdata  <= '0;
         bus.ic_done   <= 1'b0;
         bus.dc_done   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ic_req || bus.dc_req) begin
                  grant       <= pick;
                  state       <= REQ;
                  bus.ram_req <= 1'b1;
                  bus.busy    <= 1'b1;
                  if (pick == GNT_DC) begin
                     bus.ram_we    <= bus.dc_we;
                     bus.ram_addr  <= align_addr(bus.dc_addr);
                     bus.ram_wdata <= bus.dc_wdata;
                  end else begin
                     bus.ram_we    <= 1'b0;
                     bus.ram_addr  <= align_addr(bus.ic_addr);
                     bus.ram_wdata <= '0;
                  end
               end
            end
            REQ: begin
               if (bus.ram_ack || expired) begin
                  bus.ram_req <= 1'b0;
                  state       <= DONE;
                  bus.ic_done <= (grant == GNT_IC);
                  bus.dc_done <= (grant == GNT_DC);
                  if (!bus.ram_ack)
                     bus.err <= 1'b1;
                  // A timed-out read returns an all-zero line; writes leave rdata alone.
                  if (!bus.ram_we) begin
                     if (grant == GNT_DC)
                        bus.dc_rdata <= bus.ram_ack ? bus.ram_rdata : '0;
                     else
                        bus.ic_rdata <= bus.ram_ack ? bus.ram_rdata : '0;
                  end
               end
            end
            DONE: begin
               bus.ic_done <= 1'b0;
               bus.dc_done <= 1'b0;
               last_grant  <= grant;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
